// File: rtl/halfband_mac_sched_pkg.sv
// Shared types and defaults for the half-band filter MAC scheduler:
// FSM state encoding, the accumulator control token and width helpers.
package halfband_mac_sched_pkg;

    localparam int DEF_NPHASE = 4;
    localparam int DEF_NCH    = 2;
    localparam int DEF_DELAY  = 3;

    // Token channel field is fixed-width so the struct does not depend on NCH.
    localparam int TOK_CH_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                first;
        logic                last;
        logic [TOK_CH_W-1:0] ch;
    } token_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/halfband_mac_sched_ctl_delay_pipe.sv
// Fixed-latency shift pipe for control tokens; bubbles carry zeroed data so
// every downstream field is quiet whenever valid_o is low.
module ctl_delay_pipe #(
    parameter int DELAY = 3,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         empty_o
);

    logic [DELAY-1:0] vld_q;
    logic [W-1:0]     data_q [DELAY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < DELAY; i++) data_q[i] <= '0;
        end else begin
            vld_q[0]  <= valid_i;
            data_q[0] <= valid_i ? data_i : '0;
            for (int i = 1; i < DELAY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DELAY-1];
    assign data_o  = data_q[DELAY-1];
    assign empty_o = ~|vld_q;

endmodule

// File: rtl/halfband_mac_sched.sv
// Schedules one shared multiplier across NCH channels x NPHASE phases per
// sample and steers the delayed accumulator load/enable/result strobes.
module halfband_mac_sched
    import halfband_mac_sched_pkg::*;
#(
    parameter int NPHASE = DEF_NPHASE,
    parameter int NCH    = DEF_NCH,
    parameter int DELAY  = DEF_DELAY
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              enable,
    input  logic                              overrun_clr,
    output logic [clog2_min1(NCH)-1:0]        ch_sel,
    output logic [clog2_min1(NPHASE)-1:0]     phase,
    output logic [clog2_min1(2*NPHASE)-1:0]   tap_idx,
    output logic                              issue,
    output logic                              center_en,
    output logic                              acc_load,
    output logic                              acc_en,
    output logic [clog2_min1(NCH)-1:0]        acc_ch,
    output logic [NCH-1:0]                    y_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int CH_W  = clog2_min1(NCH);
    localparam int PH_W  = clog2_min1(NPHASE);
    localparam int TAP_W = clog2_min1(2*NPHASE);

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               issue_q, issue_d;
    logic               center_q, center_d;
    logic               busy_q, busy_d;
    logic               over_q, over_d;
    logic [NCH-1:0]     yv_q, yv_d;

    logic               go;
    logic               last_ph;
    logic               final_issue;
    token_t             tok_in, tok_out;
    logic               tok_vld;
    logic               pipe_empty;

    assign go          = start && enable;
    assign last_ph     = (ph_q == PH_W'(NPHASE-1));
    assign final_issue = issue_q && last_ph && (ch_q == CH_W'(NCH-1));

    // Issue fields default to zero so idle cycles present a quiet bus.
    always_comb begin
        state_d = state_q;
        ch_d    = '0;
        ph_d    = '0;
        issue_d = 1'b0;
        over_d  = over_q;
        if (overrun_clr) over_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_RUN;
                    issue_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (final_issue) begin
                    if (go) issue_d = 1'b1;
                    else    state_d = ST_DRAIN;
                end else begin
                    issue_d = 1'b1;
                    if (last_ph) begin
                        ch_d = ch_q + CH_W'(1);
                    end else begin
                        ch_d = ch_q;
                        ph_d = ph_q + PH_W'(1);
                    end
                    if (go) over_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (go) begin
                    state_d = ST_RUN;
                    issue_d = 1'b1;
                end else if (pipe_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tap_d    = TAP_W'({ph_d, 1'b0});
        center_d = issue_d && (ph_d == PH_W'(NPHASE-1));
        busy_d   = (state_d != ST_IDLE);
    end

    always_comb begin
        tok_in       = '0;
        tok_in.first = (ph_q == '0);
        tok_in.last  = last_ph;
        tok_in.ch    = TOK_CH_W'(ch_q);
        for (int k = 0; k < NCH; k++) begin
            yv_d[k] = tok_vld && tok_out.last && (tok_out.ch == TOK_CH_W'(k));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            ph_q     <= '0;
            tap_q    <= '0;
            issue_q  <= 1'b0;
            center_q <= 1'b0;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
            yv_q     <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            ph_q     <= ph_d;
            tap_q    <= tap_d;
            issue_q  <= issue_d;
            center_q <= center_d;
            busy_q   <= busy_d;
            over_q   <= over_d;
            yv_q     <= yv_d;
        end
    end

    ctl_delay_pipe #(
        .DELAY (DELAY),
        .W     ($bits(token_t))
    ) u_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (issue_q),
        .data_i  (tok_in),
        .valid_o (tok_vld),
        .data_o  (tok_out),
        .empty_o (pipe_empty)
    );

    assign ch_sel    = ch_q;
    assign phase     = ph_q;
    assign tap_idx   = tap_q;
    assign issue     = issue_q;
    assign center_en = center_q;
    assign acc_en    = tok_vld;
    assign acc_load  = tok_out.first;
    assign acc_ch    = CH_W'(tok_out.ch);
    assign y_valid   = yv_q;
    assign busy      = busy_q;
    assign overrun   = over_q;

endmodule

// File: tb/tb_halfband_mac_sched.sv
// Bench for halfband_mac_sched: default build and an NCH=1/DELAY=1 build share
// stimulus; per-cycle expectations come from the documented latency rules.
module tb_halfband_mac_sched;

    localparam int NP   = 4;
    localparam int NCYC = 45;
    localparam int NSCN = 7;

    typedef struct packed {
        logic       ch;
        logic [1:0] ph;
        logic [2:0] tap;
        logic       issue;
        logic       center;
        logic       load;
        logic       acc_en;
        logic       acc_ch;
        logic [1:0] yv;
        logic       busy;
        logic       over;
    } obs_t;

    typedef obs_t trace_t [0:NCYC];

    typedef struct {
        int s1;
        int s2;
        bit en1;
        bit en2;
        int clr_at;
        int rst_at;
        int exp_issues;
    } scn_t;

    logic clk = 1'b0;
    logic reset_n, start, enable, overrun_clr;

    logic       ch_sel1, acc_ch1, issue1, center1, load1, acc_en1, busy1, over1;
    logic [1:0] phase1, y_valid1;
    logic [2:0] tap1;
    logic       ch_sel2, acc_ch2, issue2, center2, load2, acc_en2, busy2, over2;
    logic [1:0] phase2;
    logic [0:0] y_valid2;
    logic [2:0] tap2;

    int n_vec = 0;
    int n_err = 0;

    obs_t   exp_q1[$];
    obs_t   exp_q2[$];
    scn_t   scns[NSCN];
    trace_t tr1, tr2;

    always #5 clk = ~clk;

    halfband_mac_sched dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .enable(enable),
        .overrun_clr(overrun_clr), .ch_sel(ch_sel1), .phase(phase1),
        .tap_idx(tap1), .issue(issue1), .center_en(center1),
        .acc_load(load1), .acc_en(acc_en1), .acc_ch(acc_ch1),
        .y_valid(y_valid1), .busy(busy1), .overrun(over1)
    );

    halfband_mac_sched #(.NPHASE(4), .NCH(1), .DELAY(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .enable(enable),
        .overrun_clr(overrun_clr), .ch_sel(ch_sel2), .phase(phase2),
        .tap_idx(tap2), .issue(issue2), .center_en(center2),
        .acc_load(load2), .acc_en(acc_en2), .acc_ch(acc_ch2),
        .y_valid(y_valid2), .busy(busy2), .overrun(over2)
    );

    function automatic obs_t obs1();
        return {ch_sel1, phase1, tap1, issue1, center1, load1, acc_en1,
                acc_ch1, y_valid1, busy1, over1};
    endfunction

    function automatic obs_t obs2();
        return {ch_sel2, phase2, tap2, issue2, center2, load2, acc_en2,
                acc_ch2, 1'b0, y_valid2, busy2, over2};
    endfunction

    // Expected trace from the latency rules: issue at t+1+k*NP+p, accumulator
    // input DELAY later, result strobe one cycle after the last tap leaves.
    task automatic build_exp(input int nch, input int dly, input scn_t s,
                             output trace_t tr);
        int sts[2];
        int run_end, ov_to, c, a;
        sts = '{-1, -1};
        for (int i = 0; i <= NCYC; i++) tr[i] = '0;
        run_end = s.s1 + nch*NP;
        if (s.en1) sts[0] = s.s1;
        if (s.s2 >= 0 && s.en2) begin
            if (s.en1 && s.s2 > s.s1 && s.s2 < run_end) begin
                ov_to = (s.clr_at > s.s2) ? s.clr_at : NCYC;
                for (int i = s.s2 + 1; i <= ov_to; i++) tr[i].over = 1'b1;
            end else begin
                sts[1] = s.s2;
            end
        end
        foreach (sts[j]) begin
            if (sts[j] >= 0) begin
                for (int k = 0; k < nch; k++) begin
                    for (int p = 0; p < NP; p++) begin
                        c = sts[j] + 1 + k*NP + p;
                        a = c + dly;
                        tr[c].issue  = 1'b1;
                        tr[c].ch     = k[0];
                        tr[c].ph     = 2'(p);
                        tr[c].tap    = 3'(2*p);
                        tr[c].center = (p == NP-1);
                        tr[a].acc_en = 1'b1;
                        tr[a].acc_ch = k[0];
                        tr[a].load   = (p == 0);
                    end
                    tr[sts[j] + (k+1)*NP + dly + 1].yv[k] = 1'b1;
                end
                for (int i = sts[j] + 1; i <= sts[j] + nch*NP + dly + 1; i++)
                    tr[i].busy = 1'b1;
            end
        end
        if (s.rst_at >= 0)
            for (int i = s.rst_at; i <= NCYC; i++) tr[i] = '0;
    endtask

    task automatic check(input string name, input int si, input int cyc,
                         input obs_t got, input obs_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s scn%0d cyc%0d got %h want %h", name, si, cyc, got, want);
        end
    endtask

    task automatic run_scn(input int si);
        scn_t s;
        obs_t w;
        int   n_issue;
        s = scns[si];
        build_exp(2, 3, s, tr1);
        build_exp(1, 1, s, tr2);
        reset_n = 1'b0; start = 1'b0; enable = 1'b0; overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dut1", si, -1, obs1(), '0);
        check("reset_dut2", si, -1, obs2(), '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_issue = 0;
        for (int c = 0; c <= NCYC; c++) begin
            start       = (c == s.s1) || (c == s.s2);
            enable      = (c == s.s1) ? s.en1 :
                          (c == s.s2) ? s.en2 : 1'($urandom_range(0, 1));
            overrun_clr = (c == s.clr_at);
            if (c == s.rst_at) reset_n = 1'b0;
            if (s.rst_at >= 0 && c == s.rst_at + 2) reset_n = 1'b1;
            exp_q1.push_back(tr1[c]);
            exp_q2.push_back(tr2[c]);
            @(negedge clk);
            w = exp_q1.pop_front();
            check("dut1", si, c, obs1(), w);
            w = exp_q2.pop_front();
            check("dut2", si, c, obs2(), w);
            if (issue1) n_issue++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (n_issue != s.exp_issues) begin
            n_err++;
            $display("FAIL issue_count scn%0d got %0d want %0d", si, n_issue, s.exp_issues);
        end
    endtask

    initial begin
        // s1, s2, en1, en2, clr_at, rst_at, expected dut1 issue cycles
        scns[0] = '{10, -1, 1'b1, 1'b0, -1, -1,  8};  // single sample
        scns[1] = '{10, 18, 1'b1, 1'b1, -1, -1, 16};  // restart on final issue
        scns[2] = '{10, 13, 1'b1, 1'b1, 30, -1,  8};  // overrun then clear
        scns[3] = '{10, -1, 1'b0, 1'b0, -1, -1,  0};  // enable low
        scns[4] = '{10, -1, 1'b1, 1'b0, -1, 15,  4};  // reset mid-run
        scns[5] = '{10, 21, 1'b1, 1'b1, -1, -1, 16};  // restart while draining
        scns[6] = '{10, 13, 1'b1, 1'b0, -1, -1,  8};  // start ignored, enable low
        reset_n = 1'b0; start = 1'b0; enable = 1'b0; overrun_clr = 1'b0;
        for (int i = 0; i < NSCN; i++) run_scn(i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
